// File: rtl/seq_adder_pkg.sv
// Shared types and sizing helpers for the chunked sequential adder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Chunk index width; never narrower than one bit so CHUNK == WIDTH still elaborates.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_chunk_adder_rca_chunk.sv
// CHUNK-bit combinational ripple-carry slice; msb_ci exists only with SEQ_ADDER_OVF_FLAG_EN.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module rca_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
`ifdef SEQ_ADDER_OVF_FLAG_EN
    ,
    output logic             msb_ci
`endif
);

    logic [CHUNK:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign s[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end

    assign co = c[CHUNK];

`ifdef SEQ_ADDER_OVF_FLAG_EN
    assign msb_ci = c[CHUNK-1];
`endif

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle add/sub, CHUNK bits per clock; SEQ_ADDER_OVF_FLAG_EN adds the signed overflow port ovf.
// Latency: out_valid rises WIDTH/CHUNK cycles after the accept edge.
// Backpressure: result held in DONE until out_ready; no new operand accepted until back in IDLE.
module seq_chunk_adder
    import seq_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SEQ_ADDER_OVF_FLAG_EN
    ,
    output logic             ovf
`endif
);

    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int IW     = idx_width(NCHUNK);
    localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_q, b_q, sum_q, sum_nxt;
    logic [IW-1:0]    idx_q;
    logic             carry_q, cout_q, last;
    logic [CHUNK-1:0] slice_s;
    logic             slice_co;
`ifdef SEQ_ADDER_OVF_FLAG_EN
    logic             slice_msb_ci, ovf_q;
`endif

    assign last = (idx_q == LAST_IDX);

    // Operands shift right each BUSY edge, so the slice always sees the low chunk.
    rca_chunk #(.CHUNK(CHUNK)) u_slice (
        .x      (a_q[CHUNK-1:0]),
        .y      (b_q[CHUNK-1:0]),
        .ci     (carry_q),
        .s      (slice_s),
        .co     (slice_co)
`ifdef SEQ_ADDER_OVF_FLAG_EN
        ,
        .msb_ci (slice_msb_ci)
`endif
    );

    // New chunk enters at the top; after NCHUNK edges chunk 0 has reached bit 0.
    assign sum_nxt = WIDTH'({slice_s, sum_q} >> CHUNK);

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = BUSY;
            end
            BUSY: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
`ifdef SEQ_ADDER_OVF_FLAG_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b ^ {WIDTH{sub}};
                        carry_q <= cin ^ sub;
                        idx_q   <= '0;
                    end
                end
                BUSY: begin
                    a_q     <= a_q >> CHUNK;
                    b_q     <= b_q >> CHUNK;
                    sum_q   <= sum_nxt;
                    carry_q <= slice_co;
                    idx_q   <= idx_q + 1'b1;
                    if (last) begin
                        cout_q <= slice_co;
`ifdef SEQ_ADDER_OVF_FLAG_EN
                        ovf_q  <= slice_msb_ci ^ slice_co;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SEQ_ADDER_OVF_FLAG_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Scoreboard bench for seq_chunk_adder: three instances (CHUNK = 1, 4, 16) at WIDTH = 16.
// Directed vectors run on the CHUNK=4 instance, random sweep runs on all three concurrently.
module tb_seq_chunk_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        iv[3], ir[3], ov[3], ordy[3], tcin[3], tsub[3], co[3], of[3];
    logic [15:0] ta[3], tb[3], sm[3];

    int total = 0;
    int bad   = 0;

    logic [17:0] q0[$], q1[$], q2[$];

    for (genvar g = 0; g < 3; g++) begin : u
        localparam int CHK = (g == 0) ? 1 : (g == 1) ? 4 : 16;
        if ((16 % CHK) != 0) begin : g_bad_param
            $error("WIDTH is not a multiple of CHUNK");
        end
        seq_chunk_adder #(.WIDTH(16), .CHUNK(CHK)) dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (iv[g]),
            .in_ready  (ir[g]),
            .a         (ta[g]),
            .b         (tb[g]),
            .cin       (tcin[g]),
            .sub       (tsub[g]),
            .out_valid (ov[g]),
            .out_ready (ordy[g]),
            .sum       (sm[g]),
            .cout      (co[g])
`ifdef SEQ_ADDER_OVF_FLAG_EN
            ,
            .ovf       (of[g])
`endif
        );
`ifndef SEQ_ADDER_OVF_FLAG_EN
        assign of[g] = 1'b0;
`endif
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected {ovf, cout, sum} from plain integer arithmetic and the sign rule.
    function automatic logic [17:0] model(input logic [15:0] a_, input logic [15:0] b_,
                                          input logic cin_, input logic sub_);
        logic [15:0] bb;
        logic [16:0] r;
        logic        v;
        bb = b_ ^ {16{sub_}};
        r  = {1'b0, a_} + {1'b0, bb} + {16'b0, cin_ ^ sub_};
        v  = (a_[15] == bb[15]) && (r[15] != a_[15]);
        return {v, r};
    endfunction

    task automatic push(input int i, input logic [17:0] e);
        case (i)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    function automatic int qsize(input int i);
        case (i)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic logic [17:0] pop(input int i);
        case (i)
            0: return q0.pop_front();
            1: return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    // Monitor: one pop per transfer (out_valid && out_ready sampled mid-cycle).
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst && ov[i] && ordy[i]) begin : mon
                logic [17:0] e;
                if (qsize(i) == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out inst=%0d got sum=%0h want none", i, sm[i]);
                end else begin
                    e = pop(i);
                    chk($sformatf("sum%0d", i), 32'(sm[i]), 32'(e[15:0]));
                    chk($sformatf("cout%0d", i), 32'(co[i]), 32'(e[16]));
`ifdef SEQ_ADDER_OVF_FLAG_EN
                    chk($sformatf("ovf%0d", i), 32'(of[i]), 32'(e[17]));
`endif
                end
            end
        end
    end

    task automatic issue(input int i, input logic [15:0] a_, input logic [15:0] b_,
                         input logic cin_, input logic sub_, input logic [17:0] e, input int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!ir[i] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ir[i]) begin
            chk($sformatf("in_ready_wait%0d", i), 32'(ir[i]), 32'd1);
            return;
        end
        ta[i] = a_; tb[i] = b_; tcin[i] = cin_; tsub[i] = sub_; iv[i] = 1'b1;
        @(posedge clk);
        push(i, e);
        #1 iv[i] = 1'b0;
        n = 0;
        while (!ov[i] && n < 64) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk($sformatf("latency%0d", i), 32'(n), 32'(lat));
    endtask

    task automatic run_sweep(input int i, input int lat);
        logic [15:0] ra, rb;
        logic        rc, rs;
        for (int k = 0; k < 200; k++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            issue(i, ra, rb, rc, rs, model(ra, rb, rc, rs), lat);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            iv[i] = 1'b0; ordy[i] = 1'b1; ta[i] = '0; tb[i] = '0; tcin[i] = 1'b0; tsub[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_in_ready%0d", i), 32'(ir[i]), 32'd1);
            chk($sformatf("rst_out_valid%0d", i), 32'(ov[i]), 32'd0);
            chk($sformatf("rst_sum%0d", i), 32'(sm[i]), 32'd0);
            chk($sformatf("rst_cout%0d", i), 32'(co[i]), 32'd0);
`ifdef SEQ_ADDER_OVF_FLAG_EN
            chk($sformatf("rst_ovf%0d", i), 32'(of[i]), 32'd0);
`endif
        end
        rst = 1'b0;

        // Directed: {ovf, cout, sum} hand-computed.
        issue(1, 16'h01FF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b0, 16'h0200}, 4);
        issue(1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h0000}, 4);
        issue(1, 16'hFFFF, 16'h0000, 1'b1, 1'b0, {1'b0, 1'b1, 16'h0000}, 4);
        issue(1, 16'h0005, 16'h0007, 1'b0, 1'b1, {1'b0, 1'b0, 16'hFFFE}, 4);
        issue(1, 16'h5627, 16'h1234, 1'b0, 1'b1, {1'b0, 1'b1, 16'h43F3}, 4);

        // Backpressure: let the previous result drain first, then stall 5 cycles.
        @(posedge clk);
        #1 ordy[1] = 1'b0;
        issue(1, 16'h1234, 16'h4321, 1'b0, 1'b0, {1'b0, 1'b0, 16'h5555}, 4);
        ta[1] = 16'hFFFF; tb[1] = 16'hFFFF; tcin[1] = 1'b1; tsub[1] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            iv[1] = k[0] ? 1'b0 : 1'b1;
            @(posedge clk);
            #1;
            chk("bp_out_valid", 32'(ov[1]), 32'd1);
            chk("bp_in_ready", 32'(ir[1]), 32'd0);
            chk("bp_sum", 32'(sm[1]), 32'h5555);
            chk("bp_cout", 32'(co[1]), 32'd0);
        end
        iv[1] = 1'b0;
        ordy[1] = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_drain_out_valid", 32'(ov[1]), 32'd0);
        chk("bp_drain_in_ready", 32'(ir[1]), 32'd1);

        // Reset on the second BUSY edge discards the operation.
        @(negedge clk);
        ta[1] = 16'h0F0F; tb[1] = 16'h0101; tcin[1] = 1'b0; tsub[1] = 1'b0; iv[1] = 1'b1;
        @(posedge clk);
        #1 iv[1] = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("mid_rst_in_ready", 32'(ir[1]), 32'd1);
        chk("mid_rst_out_valid", 32'(ov[1]), 32'd0);
        chk("mid_rst_sum", 32'(sm[1]), 32'd0);
        chk("mid_rst_cout", 32'(co[1]), 32'd0);
        issue(1, 16'h0001, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b0, 16'h0002}, 4);

        // Signed overflow vectors (ovf bit compared only when the port exists).
        issue(1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h8000}, 4);
        issue(1, 16'h8000, 16'h0001, 1'b0, 1'b1, {1'b1, 1'b1, 16'h7FFF}, 4);
        issue(1, 16'h0001, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b0, 16'h0002}, 4);

        // CHUNK sweep: latencies 16, 4, 1.
        fork
            run_sweep(0, 16);
            run_sweep(1, 4);
            run_sweep(2, 1);
        join

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(q0.size() + q1.size() + q2.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_chunk_adder.md
Name: seq_chunk_adder

Overview:
Parametrised multi-cycle adder/subtractor. Adds two WIDTH-bit operands CHUNK bits per clock, using one CHUNK-bit ripple-carry slice and a registered carry between slices. A valid/ready handshake sits on both input and output. It is the area-scalable successor to the fixed 16-bit combinational ripple adder, for datapaths where wide operands and low gate count matter more than single-cycle latency.

Parameters:
WIDTH, 16, operand and result width in bits; must be a multiple of CHUNK.
CHUNK, 4, bits processed per cycle; 1 ≤ CHUNK ≤ WIDTH.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
in_valid  input  1  operands present
in_ready  output  1  block can accept operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in
sub  input  1  1 = subtract (A - B), 0 = add
out_valid  output  1  result present
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result
cout  output  1  final carry-out

Behaviour:
- Reset: one clk edge with rst=1. Sets state IDLE, in_ready=1, out_valid=0, sum=0, cout=0. Clears the chunk index and the carry register. rst has priority over all other inputs, including mid-operation; any in-flight operation is discarded.
- Arithmetic: sum/cout = A + (B XOR {WIDTH{sub}}) + (cin XOR sub). With sub=1 and cin=0 this gives A - B; cout=1 means no borrow. Results wrap modulo 2^WIDTH.
- NCHUNK = WIDTH/CHUNK.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, latch a, b, cin and sub, then go to BUSY with idx=0 and carry = cin XOR sub.
  - Operands are sampled only at this accept edge.
- BUSY:
  - in_ready=0, out_valid=0.
  - Each edge computes slice idx, bits [idx*CHUNK +: CHUNK], writes it into the sum register, updates the carry, and increments idx.
  - On the edge that processes idx = NCHUNK-1, go to DONE and set cout to the final carry.
- Latency: out_valid rises exactly NCHUNK cycles after the accept edge. CHUNK=WIDTH gives 1 cycle.
- DONE:
  - out_valid=1, in_ready=0.
  - sum and cout are held stable while out_ready=0 (backpressure of any length).
  - An edge with out_ready=1 returns to IDLE and drops out_valid.
  - No same-cycle accept of a new operand in DONE. The minimum issue interval is NCHUNK+2 cycles.
- sum/cout hold their last value in IDLE. They are undefined to the consumer while out_valid=0.
- in_valid while BUSY or DONE is ignored and is not queued.
- The bench must check parameter legality (WIDTH % CHUNK == 0) via an elaboration-time assertion.

Optional Feature:
Macro: SEQ_ADDER_OVF_FLAG_EN.
- Defined: adds output port ovf (1 bit), the signed two's-complement overflow of the operation.
  - ovf = carry into MSB XOR carry out of MSB, captured on the final BUSY edge.
  - Valid with out_valid, held during backpressure, reset to 0.
- Undefined: the port and its logic are absent. No other behaviour changes.

Decomposition:
- Package seq_adder_pkg holds:
  - the state enum (IDLE, BUSY, DONE), 2-bit encoding;
  - a function computing NCHUNK;
  - an index-width helper, clog2(NCHUNK) with a minimum of 1.
- One sub-module, rca_chunk: a combinational CHUNK-bit ripple-carry slice.
  - Ports: x, y, ci, s, co, plus msb_ci when SEQ_ADDER_OVF_FLAG_EN is defined.
  - Built from full-adder cells.
- Top level holds the FSM, operand and sum registers, index counter and carry register.

Test Plan:
1. WIDTH=16, CHUNK=4: a=0x01FF, b=0x0001, cin=0, sub=0. Required: sum=0x0200, cout=0; out_valid high exactly 4 cycles after accept.
2. a=0xFFFF, b=0x0001, cin=0, then a=0xFFFF, b=0x0000, cin=1. Required: sum=0x0000, cout=1 for both; carry ripples across all 4 slices.
3. Subtract: a=0x0005, b=0x0007, sub=1, cin=0. Required: sum=0xFFFE, cout=0. Then a=0x5627, b=0x1234, sub=1. Required: sum=0x43F3, cout=1.
4. Backpressure: hold out_ready=0 for 5 cycles after out_valid. Required: sum, cout and out_valid stable; in_ready=0; in_valid pulses ignored. Result consumed on the first out_ready=1 edge, then in_ready=1 the next cycle.
5. Reset mid-operation: assert rst on the 2nd BUSY edge. Required: next cycle in_ready=1, out_valid=0, sum=0, cout=0. A new add of 0x0001+0x0001 then yields 0x0002.
6. Sweep CHUNK ∈ {1,4,16}, 200 random operand pairs each, against a reference A+B+cin model. Latency must equal 16, 4 and 1 cycles respectively. With SEQ_ADDER_OVF_FLAG_EN defined: 0x7FFF+0x0001 gives ovf=1, 0x8000-0x0001 gives ovf=1, and 0x0001+0x0001 gives ovf=0.
